bounce_engine: RTL and testbench

BOUNCE_ENGINE -- requirements
Module: bounce_engine

---
 rtl/bounce_engine.sv | 175 +++++++++++++++++
 tb/tb_bounce_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_engine.sv
// Bounce engine: N squares bouncing inside the active area. A frame pulse starts a
// pass that steps one square per clock; draw reports which squares cover (sx,sy).
module bounce_engine #(
  parameter int N         = 3,
  parameter int CORDW     = 12,
  parameter int H_RES     = 1920,
  parameter int V_RES     = 1080,
  parameter int DEF_SIZE  = 64,
  parameter int DEF_SPEED = 4
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             pause,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_idx,
  input  logic [CORDW-1:0] cfg_size,
  input  logic [CORDW-1:0] cfg_speed,
  output logic             cfg_err,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     hit,
  output logic [N-1:0]     draw
);

  localparam int                IDXW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0]   LAST    = IDXW'(N - 1);
  localparam logic [CORDW:0]    H_LIM   = (CORDW+1)'(H_RES);
  localparam logic [CORDW:0]    V_LIM   = (CORDW+1)'(V_RES);
  localparam logic [CORDW+1:0]  MIN_LIM = (CORDW+2)'((H_RES < V_RES) ? H_RES : V_RES);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t          state, state_next;
  logic [IDXW-1:0] idx, idx_next;

  logic [CORDW-1:0] pos_x   [N];
  logic [CORDW-1:0] pos_y   [N];
  logic [CORDW-1:0] size_r  [N];
  logic [CORDW-1:0] speed_r [N];
  logic             dir_x   [N];
  logic             dir_y   [N];
  logic [CORDW:0]   end_x   [N];
  logic [CORDW:0]   end_y   [N];

  logic             ready_q;
  logic [CORDW:0]   step_x, step_y;
  logic             cfg_fire, cfg_bad;
  logic [CORDW+1:0] cfg_need;
  logic [IDXW-1:0]  cfg_sel;

  // One axis step; returns {new_dir, new_pos}. The config guard keeps limit >= speed.
  function automatic logic [CORDW:0] axis_step(input logic [CORDW-1:0] pos,
                                               input logic [CORDW-1:0] size,
                                               input logic [CORDW-1:0] speed,
                                               input logic             dir,
                                               input logic [CORDW:0]   res);
    logic [CORDW:0] lim;
    lim = res - ({1'b0, size} + {1'b0, speed});
    if ({1'b0, pos} >= lim)
      return {1'b1, pos - speed};
    else if (pos < speed)
      return {1'b0, pos + speed};
    else if (dir)
      return {1'b1, pos - speed};
    else
      return {1'b0, pos + speed};
  endfunction

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (frame && !pause) begin
          state_next = UPDATE;
          idx_next   = '0;
        end
      end
      UPDATE: begin
        if (idx == LAST) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign busy = (state == UPDATE);
  assign done = busy && (idx == LAST);

  always_comb begin
    step_x = axis_step(pos_x[idx], size_r[idx], speed_r[idx], dir_x[idx], H_LIM);
    step_y = axis_step(pos_y[idx], size_r[idx], speed_r[idx], dir_y[idx], V_LIM);
  end

  // A hit is a real reversal; a square resting at 0 and already heading right/down is not.
  always_comb begin
    hit = '0;
    if (busy)
      hit[idx] = (step_x[CORDW] != dir_x[idx]) || (step_y[CORDW] != dir_y[idx]);
  end

  assign cfg_ready = ready_q && (state == IDLE) && !frame;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_need  = {2'b00, cfg_size} + {1'b0, cfg_speed, 1'b0};
  assign cfg_bad   = ({1'b0, cfg_idx} >= 5'(N)) || (cfg_speed == '0) || (cfg_need > MIN_LIM);
  assign cfg_sel   = cfg_idx[IDXW-1:0];

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        pos_x[i]   <= '0;
        pos_y[i]   <= '0;
        dir_x[i]   <= 1'b0;
        dir_y[i]   <= 1'b0;
        size_r[i]  <= CORDW'(DEF_SIZE);
        speed_r[i] <= CORDW'(DEF_SPEED);
      end
      cfg_err <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      cfg_err <= cfg_fire && cfg_bad;
      if (busy) begin
        pos_x[idx] <= step_x[CORDW-1:0];
        dir_x[idx] <= step_x[CORDW];
        pos_y[idx] <= step_y[CORDW-1:0];
        dir_y[idx] <= step_y[CORDW];
      end
      if (cfg_fire && !cfg_bad) begin
        size_r[cfg_sel]  <= cfg_size;
        speed_r[cfg_sel] <= cfg_speed;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      end_x[i] = {1'b0, pos_x[i]} + {1'b0, size_r[i]};
      end_y[i] = {1'b0, pos_y[i]} + {1'b0, size_r[i]};
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      draw <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        draw[i] <= de && (sx >= pos_x[i]) && ({1'b0, sx} < end_x[i]) &&
                   (sy >= pos_y[i]) && ({1'b0, sy} < end_y[i]);
    end
  end

endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine: reset, pass timing, edge bounce, pause,
// config validation, draw coverage and reset abort, with hand-computed values.
module tb_bounce_engine;

  localparam int N     = 3;
  localparam int CORDW = 12;

  logic             clk_pix = 1'b0;
  logic             rst_n;
  logic             frame, pause, de, cfg_valid;
  logic [CORDW-1:0] sx, sy, cfg_size, cfg_speed;
  logic [3:0]       cfg_idx;
  logic             cfg_ready, cfg_err, busy, done;
  logic [N-1:0]     hit, draw;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int dones, nbusy;

  bounce_engine #(.N(N), .CORDW(CORDW)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .pause(pause),
    .sx(sx), .sy(sy), .de(de), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_size(cfg_size), .cfg_speed(cfg_speed),
    .cfg_err(cfg_err), .busy(busy), .done(done), .hit(hit), .draw(draw)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic runFrame(output int nd);
    nd    = 0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    if (done) nd++;
    repeat (N) begin
      tick();
      if (done) nd++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] i, input int size, input int speed, input logic exp_err);
    cfg_idx   = i;
    cfg_size  = CORDW'(size);
    cfg_speed = CORDW'(speed);
    cfg_valid = 1'b1;
    checkOutput("cfg_ready_idle", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    checkOutput("cfg_err", cfg_err, exp_err);
    tick();
    checkOutput("cfg_err_one_cycle", cfg_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; frame = 1'b0; pause = 1'b0; de = 1'b0; cfg_valid = 1'b0;
    sx = '0; sy = '0; cfg_idx = '0; cfg_size = '0; cfg_speed = '0;
    repeat (2) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_draw", draw, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 0);
    rst_n = 1'b1;
    checkOutput("ready_before_edge", cfg_ready, 0);
    tick();
    checkOutput("ready_first_edge", cfg_ready, 1);

    // first pass from reset: three busy cycles, done on the last, no reversal at 0
    frame = 1'b1;
    tick();
    frame = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("pass_busy", busy, 1);
      checkOutput("pass_done", done, (c == 2) ? 1 : 0);
      checkOutput("pass_hit", hit, 0);
      checkOutput("pass_cfg_ready", cfg_ready, 0);
      tick();
    end
    checkOutput("pass_end_busy", busy, 0);
    checkOutput("pass_end_done", done, 0);
    for (int i = 0; i < N; i++) begin
      checkOutput("pass_x4", dut.pos_x[i], 4);
      checkOutput("pass_y4", dut.pos_y[i], 4);
    end

    // 463 passes total: x reaches the right limit 1852; y bounced at 1012 and is descending
    repeat (462) runFrame(dones);
    checkOutput("pre_bounce_x", dut.pos_x[0], 1852);
    checkOutput("pre_bounce_dx", dut.dir_x[0], 0);
    checkOutput("pre_bounce_y", dut.pos_y[0], 172);
    checkOutput("pre_bounce_dy", dut.dir_y[0], 1);

    frame = 1'b1;
    tick();
    frame = 1'b0;
    checkOutput("bounce_hit0", hit, 3'b001);
    tick();
    checkOutput("bounce_hit1", hit, 3'b010);
    checkOutput("bounce_x", dut.pos_x[0], 1848);
    checkOutput("bounce_dx", dut.dir_x[0], 1);
    checkOutput("bounce_y", dut.pos_y[0], 168);
    repeat (2) tick();

    frame = 1'b1;
    tick();
    frame = 1'b0;
    checkOutput("left_hit", hit, 0);
    repeat (3) tick();
    checkOutput("left_x", dut.pos_x[0], 1844);
    checkOutput("left_dx", dut.dir_x[0], 1);

    // paused frame is dropped
    pause = 1'b1;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    pause = 1'b0;
    checkOutput("pause_busy", busy, 0);
    tick();
    checkOutput("pause_busy_after", busy, 0);
    checkOutput("pause_x", dut.pos_x[0], 1844);

    // frame held into the pass must not queue a second pass
    frame = 1'b1;
    dones = 0;
    nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) frame = 1'b0;
      dones += done;
      nbusy += busy;
    end
    checkOutput("double_done_count", dones, 1);
    checkOutput("double_busy_cycles", nbusy, 3);
    checkOutput("double_x", dut.pos_x[0], 1840);

    // config writes: bad index, size+2*speed over 1080, zero speed, then accepted ones
    applyStimulus(4'd5, 64, 4, 1'b1);
    applyStimulus(4'd0, 1080, 4, 1'b1);
    applyStimulus(4'd0, 64, 0, 1'b1);
    checkOutput("cfg_keep_size0", dut.size_r[0], 64);
    checkOutput("cfg_keep_speed0", dut.speed_r[0], 4);
    checkOutput("cfg_keep_x0", dut.pos_x[0], 1840);
    applyStimulus(4'd2, 1072, 4, 1'b0);
    checkOutput("cfg_edge_size2", dut.size_r[2], 1072);
    applyStimulus(4'd1, 100, 8, 1'b0);
    checkOutput("cfg_size1", dut.size_r[1], 100);
    checkOutput("cfg_speed1", dut.speed_r[1], 8);
    checkOutput("cfg_keep_x1", dut.pos_x[1], 1840);
    checkOutput("cfg_keep_dx1", dut.dir_x[1], 1);
    runFrame(dones);
    checkOutput("cfg_move_x1", dut.pos_x[1], 1832);
    checkOutput("cfg_move_y1", dut.pos_y[1], 152);
    checkOutput("cfg_move_x0", dut.pos_x[0], 1836);
    checkOutput("cfg_move_y0", dut.pos_y[0], 156);
    checkOutput("cfg_move_x2", dut.pos_x[2], 1836);
    checkOutput("cfg_move_y2", dut.pos_y[2], 156);

    // draw coverage: all squares at (100,100), square 1 shrunk to 32
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    repeat (25) runFrame(dones);
    checkOutput("draw_setup_x", dut.pos_x[0], 100);
    checkOutput("draw_setup_y", dut.pos_y[0], 100);
    applyStimulus(4'd1, 32, 4, 1'b0);
    de = 1'b1; sx = 12'd100; sy = 12'd100;
    checkOutput("draw_latency", draw, 0);
    tick();
    checkOutput("draw_corner", draw, 3'b111);
    sx = 12'd163; sy = 12'd163;
    tick();
    checkOutput("draw_last_px", draw, 3'b101);
    sx = 12'd164;
    tick();
    checkOutput("draw_right_edge", draw, 0);
    sx = 12'd140; sy = 12'd100;
    tick();
    checkOutput("draw_small_sq", draw, 3'b101);
    sx = 12'd99;
    tick();
    checkOutput("draw_left_edge", draw, 0);
    sx = 12'd100; de = 1'b0;
    tick();
    checkOutput("draw_de_low", draw, 0);

    // reset in the middle of a pass
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    checkOutput("abort_idx", dut.idx, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_hit", hit, 0);
    checkOutput("abort_ready", cfg_ready, 0);
    checkOutput("abort_idx0", dut.idx, 0);
    checkOutput("abort_x0", dut.pos_x[0], 0);
    checkOutput("abort_size1", dut.size_r[1], 64);
    checkOutput("abort_speed1", dut.speed_r[1], 4);
    tick();
    checkOutput("abort_done_hold", done, 0);
    rst_n = 1'b1;
    tick();
    runFrame(dones);
    checkOutput("recover_done_count", dones, 1);
    for (int i = 0; i < N; i++) begin
      checkOutput("recover_x", dut.pos_x[i], 4);
      checkOutput("recover_y", dut.pos_y[i], 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
